// File: rtl/tcdm_banked_mem.sv
// Word-interleaved multi-port banked TCDM: per-bank round-robin arbitration, byte-strobed
// writes, RspLatency-cycle read responses and a saturating bank-conflict counter.
module tcdm_banked_mem #(
    parameter int unsigned NumInp     = 4,
    parameter int unsigned NrBanks    = 8,
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned TCDMDepth  = 64,
    parameter int unsigned AddrWidth  = 12,
    parameter int unsigned RspLatency = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumInp-1:0]               tcdm_req_q_valid_i,
    output logic [NumInp-1:0]               tcdm_req_q_ready_o,
    input  logic [NumInp-1:0]               tcdm_req_write_i,
    input  logic [NumInp*AddrWidth-1:0]     tcdm_req_addr_i,
    input  logic [NumInp*DataWidth-1:0]     tcdm_req_data_i,
    input  logic [NumInp*DataWidth/8-1:0]   tcdm_req_strb_i,
    output logic [NumInp-1:0]               tcdm_rsp_p_valid_o,
    output logic [NumInp*DataWidth-1:0]     tcdm_rsp_data_o,
    input  logic                            conflict_clr_i,
    output logic [31:0]                     conflict_cnt_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned OffW      = $clog2(StrbWidth);
    localparam int unsigned BankW     = $clog2(NrBanks);
    localparam int unsigned RowW      = $clog2(TCDMDepth);
    localparam int unsigned PortW     = (NumInp > 1) ? $clog2(NumInp) : 1;
    localparam int unsigned CntW      = $clog2(NumInp + 1);

    if (AddrWidth != $clog2(NrBanks * TCDMDepth * StrbWidth)) begin : g_err_addr
        $error("AddrWidth must equal clog2(NrBanks*TCDMDepth*DataWidth/8)");
    end
    if (RspLatency == 0 || RspLatency > 4) begin : g_err_lat
        $error("RspLatency must be in the range 1..4");
    end

    // ------------------------------------------------------------------
    // Per-port request decode
    // ------------------------------------------------------------------
    logic [BankW-1:0]     port_bank  [NumInp];
    logic [RowW-1:0]      port_row   [NumInp];
    logic [DataWidth-1:0] port_wdata [NumInp];
    logic [StrbWidth-1:0] port_strb  [NumInp];
    logic [OffW-1:0]      unused_addr_off [NumInp];

    for (genvar p = 0; p < NumInp; p++) begin : g_dec
        assign port_bank[p]  = tcdm_req_addr_i[p*AddrWidth+OffW +: BankW];
        assign port_row[p]   = tcdm_req_addr_i[p*AddrWidth+OffW+BankW +: RowW];
        assign port_wdata[p] = tcdm_req_data_i[p*DataWidth +: DataWidth];
        assign port_strb[p]  = tcdm_req_strb_i[p*StrbWidth +: StrbWidth];
        // Byte offset within a word carries no information for word accesses.
        assign unused_addr_off[p] = tcdm_req_addr_i[p*AddrWidth +: OffW];
    end

    // ------------------------------------------------------------------
    // Per-bank round-robin arbitration
    // ------------------------------------------------------------------
    logic [NumInp-1:0]  bank_req [NrBanks];
    logic [NrBanks-1:0] bank_gnt;
    logic [PortW-1:0]   bank_win [NrBanks];
    logic [PortW-1:0]   rr_ptr_q [NrBanks];

    always_comb begin
        for (int unsigned b = 0; b < NrBanks; b++) begin
            bank_req[b] = '0;
            for (int unsigned p = 0; p < NumInp; p++) begin
                bank_req[b][p] = tcdm_req_q_valid_i[p] && (port_bank[p] == BankW'(b));
            end
        end
    end

    // First pass scans ports at or above the pointer, second pass wraps to the lowest.
    always_comb begin
        for (int unsigned b = 0; b < NrBanks; b++) begin
            bank_gnt[b] = 1'b0;
            bank_win[b] = '0;
            for (int unsigned i = 0; i < NumInp; i++) begin
                if (!bank_gnt[b] && (i >= 32'(rr_ptr_q[b])) && bank_req[b][i]) begin
                    bank_gnt[b] = 1'b1;
                    bank_win[b] = PortW'(i);
                end
            end
            for (int unsigned i = 0; i < NumInp; i++) begin
                if (!bank_gnt[b] && bank_req[b][i]) begin
                    bank_gnt[b] = 1'b1;
                    bank_win[b] = PortW'(i);
                end
            end
        end
    end

    always_comb begin
        for (int unsigned p = 0; p < NumInp; p++) begin
            tcdm_req_q_ready_o[p] = tcdm_req_q_valid_i[p] && bank_gnt[port_bank[p]] &&
                                    (bank_win[port_bank[p]] == PortW'(p));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned b = 0; b < NrBanks; b++) begin
                rr_ptr_q[b] <= '0;
            end
        end else begin
            for (int unsigned b = 0; b < NrBanks; b++) begin
                if (bank_gnt[b]) begin
                    rr_ptr_q[b] <= (bank_win[b] == PortW'(NumInp - 1)) ? '0
                                                                         : bank_win[b] + PortW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Bank access: winner's request steered to each bank
    // ------------------------------------------------------------------
    logic [NrBanks-1:0]   bank_we;
    logic [NrBanks-1:0]   bank_re;
    logic [RowW-1:0]      bank_row   [NrBanks];
    logic [DataWidth-1:0] bank_wdata [NrBanks];
    logic [StrbWidth-1:0] bank_strb  [NrBanks];
    logic [DataWidth-1:0] bank_rdata [NrBanks];

    always_comb begin
        for (int unsigned b = 0; b < NrBanks; b++) begin
            bank_we[b]    = bank_gnt[b] && tcdm_req_write_i[bank_win[b]];
            bank_re[b]    = bank_gnt[b] && !tcdm_req_write_i[bank_win[b]];
            bank_row[b]   = port_row[bank_win[b]];
            bank_wdata[b] = port_wdata[bank_win[b]];
            bank_strb[b]  = port_strb[bank_win[b]];
        end
    end

    for (genvar b = 0; b < NrBanks; b++) begin : g_bank
        logic [DataWidth-1:0] mem_q [TCDMDepth];
        logic [DataWidth-1:0] rdata_q;

        // Storage is intentionally not reset.
        always_ff @(posedge clk_i) begin
            if (bank_we[b]) begin
                for (int unsigned i = 0; i < StrbWidth; i++) begin
                    if (bank_strb[b][i]) begin
                        mem_q[bank_row[b]][i*8 +: 8] <= bank_wdata[b][i*8 +: 8];
                    end
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rdata_q <= '0;
            end else if (bank_re[b]) begin
                rdata_q <= mem_q[bank_row[b]];
            end
        end

        assign bank_rdata[b] = rdata_q;
    end

    // ------------------------------------------------------------------
    // Read response routing and latency pipeline
    // ------------------------------------------------------------------
    logic [NumInp-1:0]    rd_vld_q;
    logic [BankW-1:0]     rd_bank_q [NumInp];
    logic [DataWidth-1:0] rd_data   [NumInp];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_vld_q <= '0;
            for (int unsigned p = 0; p < NumInp; p++) begin
                rd_bank_q[p] <= '0;
            end
        end else begin
            rd_vld_q <= tcdm_req_q_ready_o & ~tcdm_req_write_i;
            for (int unsigned p = 0; p < NumInp; p++) begin
                if (tcdm_req_q_ready_o[p] && !tcdm_req_write_i[p]) begin
                    rd_bank_q[p] <= port_bank[p];
                end
            end
        end
    end

    for (genvar p = 0; p < NumInp; p++) begin : g_rd_route
        assign rd_data[p] = bank_rdata[rd_bank_q[p]];
    end

    if (RspLatency <= 1) begin : g_rsp_direct
        assign tcdm_rsp_p_valid_o = rd_vld_q;
        for (genvar p = 0; p < NumInp; p++) begin : g_out
            assign tcdm_rsp_data_o[p*DataWidth +: DataWidth] = rd_data[p];
        end
    end else begin : g_rsp_pipe
        localparam int unsigned Depth = RspLatency - 1;
        logic [NumInp-1:0]           vld_q [Depth];
        logic [NumInp*DataWidth-1:0] dat_q [Depth];
        logic [NumInp*DataWidth-1:0] rd_data_flat;

        for (genvar p = 0; p < NumInp; p++) begin : g_flat
            assign rd_data_flat[p*DataWidth +: DataWidth] = rd_data[p];
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int unsigned s = 0; s < Depth; s++) begin
                    vld_q[s] <= '0;
                    dat_q[s] <= '0;
                end
            end else begin
                vld_q[0] <= rd_vld_q;
                dat_q[0] <= rd_data_flat;
                for (int unsigned s = 1; s < Depth; s++) begin
                    vld_q[s] <= vld_q[s-1];
                    dat_q[s] <= dat_q[s-1];
                end
            end
        end

        assign tcdm_rsp_p_valid_o = vld_q[Depth-1];
        assign tcdm_rsp_data_o    = dat_q[Depth-1];
    end

    // ------------------------------------------------------------------
    // Saturating conflict counter
    // ------------------------------------------------------------------
    logic [CntW-1:0] stall_num;
    logic [32:0]     cnt_sum;
    logic [31:0]     cnt_d, cnt_q;

    always_comb begin
        stall_num = '0;
        for (int unsigned p = 0; p < NumInp; p++) begin
            stall_num = stall_num + CntW'(tcdm_req_q_valid_i[p] & ~tcdm_req_q_ready_o[p]);
        end
        cnt_sum = {1'b0, cnt_q} + 33'(stall_num);
        cnt_d   = cnt_sum[32] ? '1 : cnt_sum[31:0];
        if (conflict_clr_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_tcdm_banked_mem.sv
// Directed bench for tcdm_banked_mem: four instances (RspLatency 1..4) share one stimulus
// stream; read responses are checked against a scoreboard of expected {cycle, port, data}.
module tb_tcdm_banked_mem;

    localparam int unsigned NumInp    = 4;
    localparam int unsigned NrBanks   = 8;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned TCDMDepth = 64;
    localparam int unsigned AddrWidth = 12;
    localparam int unsigned NumDut    = 4;

    localparam logic [63:0] D0  = 64'h0000_0000_abcd_1234;
    localparam logic [63:0] D8  = 64'h0000_0000_5555_ffff;
    localparam logic [63:0] D64 = 64'h1122_3344_5566_7788;

    typedef struct {
        int          dut;
        int          port;
        int          due;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];

    logic                          clk;
    logic                          rst_ni;
    logic [NumInp-1:0]             req_valid;
    logic [NumInp-1:0]             req_write;
    logic [NumInp*AddrWidth-1:0]   req_addr;
    logic [NumInp*DataWidth-1:0]   req_data;
    logic [NumInp*DataWidth/8-1:0] req_strb;
    logic                          clr;

    logic [NumInp-1:0]           ready     [NumDut];
    logic [NumInp-1:0]           rsp_valid [NumDut];
    logic [NumInp*DataWidth-1:0] rsp_data  [NumDut];
    logic [31:0]                 cnt       [NumDut];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    for (genvar g = 0; g < NumDut; g++) begin : g_dut
        tcdm_banked_mem #(
            .NumInp     (NumInp),
            .NrBanks    (NrBanks),
            .DataWidth  (DataWidth),
            .TCDMDepth  (TCDMDepth),
            .AddrWidth  (AddrWidth),
            .RspLatency (g + 1)
        ) u_dut (
            .clk_i              (clk),
            .rst_ni             (rst_ni),
            .tcdm_req_q_valid_i (req_valid),
            .tcdm_req_q_ready_o (ready[g]),
            .tcdm_req_write_i   (req_write),
            .tcdm_req_addr_i    (req_addr),
            .tcdm_req_data_i    (req_data),
            .tcdm_req_strb_i    (req_strb),
            .tcdm_rsp_p_valid_o (rsp_valid[g]),
            .tcdm_rsp_data_o    (rsp_data[g]),
            .conflict_clr_i     (clr),
            .conflict_cnt_o     (cnt[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_data  = '0;
        req_strb  = '0;
        clr       = 1'b0;
    endtask

    task automatic set_req(input int p, input logic w, input logic [AddrWidth-1:0] a,
                           input logic [63:0] d, input logic [7:0] s);
        req_valid[p]                    = 1'b1;
        req_write[p]                    = w;
        req_addr[p*AddrWidth +: AddrWidth] = a;
        req_data[p*64 +: 64]            = d;
        req_strb[p*8 +: 8]              = s;
    endtask

    task automatic chk_ready(input logic [3:0] e);
        for (int g = 0; g < NumDut; g++) begin
            check($sformatf("ready_d%0d_c%0d", g, cyc), 64'(ready[g]), 64'(e));
        end
    endtask

    task automatic chk_cnt(input logic [31:0] e);
        for (int g = 0; g < NumDut; g++) begin
            check($sformatf("conflict_cnt_d%0d_c%0d", g, cyc), 64'(cnt[g]), 64'(e));
        end
    endtask

    task automatic chk_reset_state();
        chk_ready(4'b0000);
        chk_cnt(32'd0);
        for (int g = 0; g < NumDut; g++) begin
            for (int p = 0; p < NumInp; p++) begin
                check($sformatf("rst_data_d%0d_p%0d", g, p), rsp_data[g][p*64 +: 64], 64'd0);
            end
        end
    endtask

    // Expect a read response from instances 0..n_dut-1 (latency g+1).
    task automatic push_rd(input int p, input logic [63:0] d, input int n_dut);
        for (int g = 0; g < n_dut; g++) begin
            sb.push_back('{dut: g, port: p, due: cyc + g + 1, data: d});
        end
    endtask

    task automatic check_rsp();
        for (int g = 0; g < NumDut; g++) begin
            for (int p = 0; p < NumInp; p++) begin
                int idx;
                idx = -1;
                foreach (sb[i]) begin
                    if (sb[i].dut == g && sb[i].port == p && sb[i].due == cyc) idx = i;
                end
                if (idx >= 0) begin
                    check($sformatf("rsp_valid_d%0d_p%0d_c%0d", g, p, cyc),
                          64'(rsp_valid[g][p]), 64'd1);
                    check($sformatf("rsp_data_d%0d_p%0d_c%0d", g, p, cyc),
                          rsp_data[g][p*64 +: 64], sb[idx].data);
                    sb.delete(idx);
                end else begin
                    check($sformatf("rsp_valid_d%0d_p%0d_c%0d", g, p, cyc),
                          64'(rsp_valid[g][p]), 64'd0);
                end
            end
        end
    endtask

    task automatic tick();
        check_rsp();
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            idle();
            #1;
            tick();
        end
    endtask

    initial begin
        // T1: reset state
        idle();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_rsp();
        chk_reset_state();
        rst_ni = 1'b1;
        @(negedge clk);
        cyc = 0;

        // T2: two writes, then two reads, to different banks
        idle(); set_req(0, 1'b1, 12'd0, D0, 8'hff); set_req(1, 1'b1, 12'd8, D8, 8'hff);
        #1; chk_ready(4'b0011); tick();
        idle(); set_req(0, 1'b0, 12'd0, '0, '0); set_req(1, 1'b0, 12'd8, '0, '0);
        #1; chk_ready(4'b0011); chk_cnt(0); push_rd(0, D0, 4); push_rd(1, D8, 4); tick();
        // All four ports on distinct banks in one cycle
        idle(); set_req(0, 1'b0, 12'd0, '0, '0); set_req(1, 1'b0, 12'd8, '0, '0);
        set_req(2, 1'b1, 12'd40, 64'h4040, 8'hff); set_req(3, 1'b1, 12'd56, 64'h5656, 8'hff);
        #1; chk_ready(4'b1111); push_rd(0, D0, 4); push_rd(1, D8, 4); tick();

        // Prep: fill addr 64, then a strobe-less write from p3 brings bank 0's pointer to 0
        idle(); set_req(1, 1'b1, 12'd64, D64, 8'hff);
        #1; chk_ready(4'b0010); tick();
        idle(); set_req(3, 1'b1, 12'd0, 64'hdead_beef_dead_beef, 8'h00);
        #1; chk_ready(4'b1000); tick();

        // T3: bank conflict on bank 0
        idle(); set_req(0, 1'b0, 12'd0, '0, '0); set_req(1, 1'b0, 12'd64, '0, '0);
        #1; chk_ready(4'b0001); chk_cnt(0); push_rd(0, D0, 4); tick();
        idle(); set_req(1, 1'b0, 12'd64, '0, '0);
        #1; chk_ready(4'b0010); chk_cnt(1); push_rd(1, D64, 4); tick();
        drain(5);
        chk_cnt(1);

        // T4 prep: one row of bank 3 per port; clear the counter on the last write
        for (int p = 0; p < 4; p++) begin
            idle(); set_req(p, 1'b1, 12'(24 + 64 * p), 64'hb3b3_0000_0000_0000 + 64'(p), 8'hff);
            clr = (p == 3);
            #1; chk_ready(4'(1 << p)); tick();
        end
        // T4: all ports hammer bank 3 for 8 cycles
        for (int k = 0; k < 8; k++) begin
            idle();
            for (int p = 0; p < 4; p++) set_req(p, 1'b0, 12'(24 + 64 * p), '0, '0);
            #1;
            if (k == 0) chk_cnt(0);
            chk_ready(4'(1 << (k % 4)));
            push_rd(k % 4, 64'hb3b3_0000_0000_0000 + 64'(k % 4), 4);
            tick();
        end
        idle(); #1; chk_cnt(24); tick();
        drain(5);

        // T5: byte strobes
        idle(); set_req(0, 1'b1, 12'd16, '1, 8'hff);
        #1; chk_ready(4'b0001); tick();
        idle(); set_req(0, 1'b1, 12'd16, 64'd0, 8'h0f);
        #1; chk_ready(4'b0001); tick();
        idle(); set_req(0, 1'b0, 12'd16, '0, '0);
        #1; chk_ready(4'b0001); push_rd(0, 64'hffff_ffff_0000_0000, 4); tick();
        drain(5);

        // T6: reset one cycle after a read grant; only the latency-1 instance responds
        idle(); set_req(0, 1'b0, 12'd0, '0, '0);
        #1; chk_ready(4'b0001); push_rd(0, D0, 1); tick();
        idle(); #1; check_rsp(); rst_ni = 1'b0; @(negedge clk); cyc++;
        #1; check_rsp(); chk_reset_state(); rst_ni = 1'b1; @(negedge clk); cyc++;
        // Pointer back to 0: p0 must beat p1 on bank 0
        idle(); set_req(0, 1'b0, 12'd0, '0, '0); set_req(1, 1'b0, 12'd64, '0, '0);
        #1; chk_ready(4'b0001); chk_cnt(0); push_rd(0, D0, 4); tick();
        idle(); set_req(1, 1'b0, 12'd64, '0, '0);
        #1; chk_ready(4'b0010); chk_cnt(1); push_rd(1, D64, 4); tick();

        // Clear wins over a same-cycle increment
        idle(); set_req(0, 1'b0, 12'd0, '0, '0); set_req(1, 1'b0, 12'd64, '0, '0); clr = 1'b1;
        #1; chk_ready(4'b0001); push_rd(0, D0, 4); tick();
        idle(); set_req(1, 1'b0, 12'd64, '0, '0);
        #1; chk_cnt(0); chk_ready(4'b0010); push_rd(1, D64, 4); tick();
        idle(); #1; chk_cnt(0); tick();
        drain(6);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
